cacheline_adaptor: RTL and testbench

Bridges the cache's 256-bit physical-memory port to a narrow burst memory bus. It accepts one line read or line write per transaction from the cache. It moves the line as `256/BURST_W` consecutive beats and returns a single-cycle `pmem_resp` to the cache. It sits directly downstream of the two-way cache datapath/controller, between the cache and main memory.

---
 rtl/cacheline_adaptor.sv | 151 +++++++++++++++
 tb/tb_cacheline_adaptor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges the cache's 256-bit line port to a narrow burst bus.
//
// Each cache transaction (line read or line write) moves 256/BURST_W consecutive
// beats on the bus. When the last beat is done, a one-cycle pmem_resp goes back
// to the cache. Request inputs are latched when the request is accepted.
// Changes to them during a transfer are ignored.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   pmem_address      line address from the cache (bits [4:0] ignored)
//   pmem_read/write   line request, held by the cache until pmem_resp
//   pmem_wdata        line to write
//   pmem_rdata        line buffer contents, valid when pmem_resp = 1
//   pmem_resp         one-cycle transaction-complete pulse
//   bus_address       {latched addr[31:5], 5'b0}
//   bus_read/write    burst read / write active
//   bus_wdata         current write beat
//   bus_rdata         read beat, sampled when bus_resp = 1
//   bus_resp          one beat transferred this cycle
//   err               (CACHELINE_ADAPTOR_CHECK_EN only) sticky protocol-violation flag
//
// Define CACHELINE_ADAPTOR_CHECK_EN to add the err output and its checker.

module cacheline_adaptor #(
  parameter int unsigned BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pmem_address,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [255:0]       pmem_wdata,
  output logic [255:0]       pmem_rdata,
  output logic               pmem_resp,
  output logic [31:0]        bus_address,
  output logic               bus_read,
  output logic               bus_write,
  output logic [BURST_W-1:0] bus_wdata,
  input  logic [BURST_W-1:0] bus_rdata,
  input  logic               bus_resp
`ifdef CACHELINE_ADAPTOR_CHECK_EN
  ,
  output logic               err
`endif
);

  localparam int unsigned BEATS = 256 / BURST_W;
  // Keep the counter at least one bit wide so that BEATS = 1 still elaborates.
  localparam int unsigned CntW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [26:0]     addr_q, addr_d;
  logic [255:0]    line_q, line_d;
  logic [8:0]      beat_base;

  // Bit offset of the current beat within the line; beat 0 is least significant.
  assign beat_base = 9'(cnt_q) * 9'(BURST_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    unique case (state_q)
      StIdle: begin
        // Write wins when both requests are presented.
        if (pmem_write) begin
          state_d = StWr;
          addr_d  = pmem_address[31:5];
          cnt_d   = '0;
          line_d  = pmem_wdata;
        end else if (pmem_read) begin
          state_d = StRd;
          addr_d  = pmem_address[31:5];
          cnt_d   = '0;
        end
      end
      StRd: begin
        if (bus_resp) begin
          line_d[beat_base +: BURST_W] = bus_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) state_d = StDone;
        end
      end
      StWr: begin
        if (bus_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    pmem_rdata  = line_q;
    pmem_resp   = (state_q == StDone);
    bus_address = {addr_q, 5'b0};
    bus_read    = (state_q == StRd);
    bus_write   = (state_q == StWr);
    bus_wdata   = (state_q == StWr) ? line_q[beat_base +: BURST_W] : '0;
  end

`ifdef CACHELINE_ADAPTOR_CHECK_EN
  logic rd_prev_q, wr_prev_q, err_q, err_set;

  // The previous-cycle request values let us detect a request that changes while a
  // transfer is running. In the first RD/WR cycle they hold the accepted values.
  always_comb begin
    err_set = 1'b0;
    if ((state_q == StIdle || state_q == StDone) && bus_resp) err_set = 1'b1;
    if (state_q == StIdle && pmem_read && pmem_write) err_set = 1'b1;
    if ((state_q == StRd || state_q == StWr) &&
        (pmem_read != rd_prev_q || pmem_write != wr_prev_q)) err_set = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rd_prev_q <= pmem_read;
      wr_prev_q <= pmem_write;
      err_q     <= err_q | err_set;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  bus_address;
  logic         bus_read, bus_write;
  logic [63:0]  bus_wdata, bus_rdata;
  logic         bus_resp;
`ifdef CACHELINE_ADAPTOR_CHECK_EN
  logic         err;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [255:0] sb_q[$];

  always #5 clk = ~clk;

  cacheline_adaptor #(.BURST_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .bus_address  (bus_address),
    .bus_read     (bus_read),
    .bus_write    (bus_write),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_resp     (bus_resp)
`ifdef CACHELINE_ADAPTOR_CHECK_EN
    ,
    .err          (err)
`endif
  );

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One cache transaction. For a read, 'line' supplies the bus beats; for a write
  // it is the line written. Either way it is what pmem_rdata must show at pmem_resp.
  // pat[i] is bus_resp for the i-th active bus cycle (1 beyond plen).
  task automatic xfer(input bit is_wr, input bit both, input logic [31:0] addr,
                      input logic [255:0] line, input logic [15:0] pat, input int plen);
    int n, p, k;
    bit done;
    n = 0; p = 0; k = 0; done = 0;
    pmem_address = addr;
    pmem_read    = !is_wr || both;
    pmem_write   = is_wr;
    pmem_wdata   = is_wr ? line : ~line;
    sb_q.push_back(line);
    while (!done) begin
      @(negedge clk);
      n++;
      bus_resp = 1'b0;
      if (n == 1) begin
        check_val("bus_address", bus_address, {addr[31:5], 5'b0});
        check_val("bus_read", bus_read, !is_wr);
        check_val("bus_write", bus_write, is_wr);
        if (is_wr) check_val("rdata_after_wr_accept", pmem_rdata, line);
      end
      if (pmem_resp) begin
        check_val("pmem_rdata", pmem_rdata, sb_q.pop_front());
        check_val("latency", n, 1 + p);
        check_val("strobes_in_done", {bus_read, bus_write}, 2'b00);
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        done = 1;
      end else if (n > 40) begin
        check_val("timeout_pmem_resp", pmem_resp, 1'b1);
        void'(sb_q.pop_front());
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        done = 1;
      end else if (is_wr ? bus_write : bus_read) begin
        if (is_wr && k < 4) check_val("bus_wdata", bus_wdata, line[k*64 +: 64]);
        bus_resp = (p < plen) ? pat[p] : 1'b1;
        if (bus_resp && k < 4) begin
          bus_rdata = line[k*64 +: 64];
          k++;
        end else begin
          bus_rdata = {$urandom, $urandom};
        end
        p++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] rd_line, wr_line;
    rst = 1'b1;
    pmem_address = '0; pmem_read = 0; pmem_write = 0; pmem_wdata = '0;
    bus_rdata = '0; bus_resp = 0;
    repeat (2) @(negedge clk);
    check_val("reset_outputs",
              {pmem_rdata, pmem_resp, bus_address, bus_read, bus_write, bus_wdata}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Read, no waits.
    rd_line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    xfer(0, 0, 32'h0000_1234, rd_line, 16'h0000, 0);
    @(negedge clk);

    // Write with waits: resp pattern 1,0,0,1,1,0,1 (bit 0 first).
    wr_line = rand_line();
    xfer(1, 0, 32'hABCD_EF7F, wr_line, 16'b1011001, 7);
    @(negedge clk);
`ifdef CACHELINE_ADAPTOR_CHECK_EN
    check_val("err_clean", err, 1'b0);
`endif

    // Back-to-back read then write with one idle cycle between.
    rd_line = rand_line();
    xfer(0, 0, 32'h8000_0040, rd_line, 16'b0110, 4);
    @(negedge clk);
    check_val("rdata_hold_idle", pmem_rdata, rd_line);
    wr_line = rand_line();
    xfer(1, 0, 32'h1234_5660, wr_line, 16'h0000, 0);
    @(negedge clk);
    check_val("rdata_hold_after_wr", pmem_rdata, wr_line);

    // Both requests: write wins.
    wr_line = rand_line();
    xfer(1, 1, 32'h0000_0F00, wr_line, 16'b10, 2);
`ifdef CACHELINE_ADAPTOR_CHECK_EN
    check_val("err_both", err, 1'b1);
    repeat (3) @(negedge clk);
    check_val("err_sticky", err, 1'b1);
`endif
    @(negedge clk);

    // Reset after beat 2 of a read.
    rd_line = rand_line();
    pmem_address = 32'h0000_2000;
    pmem_read = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus_resp  = 1'b1;
      bus_rdata = rd_line[i*64 +: 64];
    end
    @(negedge clk);
    bus_resp = 1'b0;
    check_val("rd_before_rst", bus_read, 1'b1);
    rst = 1'b1;
    #1;
    check_val("rst_bus_read", bus_read, 1'b0);
    check_val("rst_rdata", pmem_rdata, '0);
    check_val("rst_resp", pmem_resp, 1'b0);
    pmem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("no_resp_after_rst", pmem_resp, 1'b0);
    end
`ifdef CACHELINE_ADAPTOR_CHECK_EN
    check_val("err_cleared", err, 1'b0);
`endif
    rd_line = rand_line();
    xfer(0, 0, 32'h0000_3000, rd_line, 16'h0000, 0);
    @(negedge clk);

    // Stray bus_resp in IDLE, then a normal read.
    bus_resp = 1'b1;
    @(negedge clk);
    bus_resp = 1'b0;
    @(negedge clk);
    rd_line = rand_line();
    xfer(0, 0, 32'hFFFF_FFE0, rd_line, 16'h0000, 0);
`ifdef CACHELINE_ADAPTOR_CHECK_EN
    check_val("err_stray", err, 1'b1);
`endif
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
